// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display arbiter: display codes,
// the dark frame, the owner FSM states and the src encodings.
package disp_pkg;

    typedef enum logic [3:0] {
        CODE_DARK = 4'hA,
        CODE_P    = 4'hB,
        CODE_W    = 4'hC,
        CODE_I    = 4'hD,
        CODE_N    = 4'hE,
        CODE_A    = 4'hF
    } code_t;

    localparam logic [15:0] DARK_FRAME = {4{CODE_DARK}};

    typedef enum logic [1:0] {
        S_BASE  = 2'd0,
        S_ALERT = 2'd1,
        S_WIN   = 2'd2
    } state_t;

    localparam logic [1:0] SRC_BASE  = 2'd0;
    localparam logic [1:0] SRC_ALERT = 2'd1;
    localparam logic [1:0] SRC_WIN   = 2'd2;

endpackage

// File: rtl/display_arbiter_if.sv
// Frame sources and display-driver bus of the display arbiter; the arbiter
// takes the slave modport, the frame sources and driver side take master.
interface display_arbiter_if;

    logic [15:0] base_code;
    logic        alert_req;
    logic [15:0] alert_code;
    logic        alert_ack;
    logic        win_req;
    logic [15:0] win_code;
    logic        win_ack;
    logic        win_clr;
    logic [15:0] bcds;
    logic [1:0]  src;

    modport slave (
        input  base_code, alert_req, alert_code, win_req, win_code, win_clr,
        output alert_ack, win_ack, bcds, src
    );

    modport master (
        output base_code, alert_req, alert_code, win_req, win_code, win_clr,
        input  alert_ack, win_ack, bcds, src
    );

endinterface

// File: rtl/disp_tick_gen.sv
// Tick prescaler: one-cycle tick every TICK_DIV cycles, realigned by restart
// so the first tick lands exactly TICK_DIV cycles after the restart edge.
module disp_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the 4-digit display: win banner > alert > base frame.
// Define DISP_BLINK_EN to blink the alert frame every BLINK_TICKS ticks.
module display_arbiter
    import disp_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int ALERT_TICKS = 1000,
    parameter int BLINK_TICKS = 250
) (
    input logic              clk,
    input logic              rst_n,
    display_arbiter_if.slave bus
);

    localparam int AW = $clog2(ALERT_TICKS + 1);

    state_t          state;
    logic [15:0]     bcds_q;
    logic [15:0]     alert_frame;
    logic [15:0]     win_frame;
    logic [1:0]      src_q;
    logic            alert_ack_q;
    logic            win_ack_q;
    logic [AW-1:0]   alert_cnt;
    logic            take_win;
    logic            take_alert;
    logic            tick;

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);
    logic [BW-1:0]   blink_cnt;
    logic            blink_on;
`else
    logic            unused_blink_cfg;
    assign unused_blink_cfg = ^BLINK_TICKS;
`endif

    // A req still high in the ack cycle is the old request, not a new one.
    assign take_win   = (state != S_WIN) && bus.win_req;
    assign take_alert = (state != S_WIN) && !bus.win_req && bus.alert_req && !alert_ack_q;

    disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (take_alert),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BASE;
            bcds_q      <= DARK_FRAME;
            src_q       <= SRC_BASE;
            alert_ack_q <= 1'b0;
            win_ack_q   <= 1'b0;
            alert_frame <= DARK_FRAME;
            win_frame   <= DARK_FRAME;
            alert_cnt   <= '0;
`ifdef DISP_BLINK_EN
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
`endif
        end else begin
            alert_ack_q <= 1'b0;
            win_ack_q   <= 1'b0;
            unique case (state)
                S_BASE, S_ALERT: begin
                    if (take_win) begin
                        state     <= S_WIN;
                        win_frame <= bus.win_code;
                        win_ack_q <= 1'b1;
                        bcds_q    <= bus.win_code;
                        src_q     <= SRC_WIN;
                        alert_cnt <= '0;
                    end else if (take_alert) begin
                        state       <= S_ALERT;
                        alert_frame <= bus.alert_code;
                        alert_ack_q <= 1'b1;
                        bcds_q      <= bus.alert_code;
                        src_q       <= SRC_ALERT;
                        alert_cnt   <= AW'(ALERT_TICKS);
`ifdef DISP_BLINK_EN
                        blink_cnt   <= BW'(BLINK_TICKS);
                        blink_on    <= 1'b1;
`endif
                    end else if (state == S_ALERT && tick) begin
                        alert_cnt <= alert_cnt - 1'b1;
                        if (alert_cnt == AW'(1)) begin
                            state  <= S_BASE;
                            bcds_q <= bus.base_code;
                            src_q  <= SRC_BASE;
                        end
`ifdef DISP_BLINK_EN
                        else if (blink_cnt == BW'(1)) begin
                            blink_on  <= !blink_on;
                            blink_cnt <= BW'(BLINK_TICKS);
                            bcds_q    <= blink_on ? DARK_FRAME : alert_frame;
                        end else begin
                            blink_cnt <= blink_cnt - 1'b1;
                        end
`endif
                    end else if (state == S_BASE) begin
                        bcds_q <= bus.base_code;
                    end
                end
                S_WIN: begin
                    // Clear beats a same-cycle win_req; that req is served from S_BASE.
                    if (bus.win_clr) begin
                        state  <= S_BASE;
                        bcds_q <= bus.base_code;
                        src_q  <= SRC_BASE;
                    end
                end
                default: begin
                    state <= S_BASE;
                    src_q <= SRC_BASE;
                end
            endcase
        end
    end

    assign bus.bcds      = bcds_q;
    assign bus.src       = src_q;
    assign bus.alert_ack = alert_ack_q;
    assign bus.win_ack   = win_ack_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus random
// traffic, compared every cycle against a time-based behavioural model.
`timescale 1ns/1ps
module tb_display_arbiter;
    import disp_pkg::*;

    localparam int TD = 4;
    localparam int AT = 3;
    localparam int BT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    display_arbiter_if bus();

    display_arbiter #(.TICK_DIV(TD), .ALERT_TICKS(AT), .BLINK_TICKS(BT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: who owns the display and when the current alert was accepted.
    int          m_owner;
    int          m_astart;
    logic [15:0] m_bcds, m_aframe, m_wframe;
    logic [1:0]  m_src;
    logic        m_aack, m_wack;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_bcds  = DARK_FRAME;
        m_src   = SRC_BASE;
        m_aack  = 1'b0;
        m_wack  = 1'b0;
    endtask

    function automatic bit alert_visible(int age);
`ifdef DISP_BLINK_EN
        return ((age / (BT * TD)) % 2) == 0;
`else
        return (age >= 0);
`endif
    endfunction

    task automatic model_step();
        logic prev_aack;
        prev_aack = m_aack;
        m_aack = 1'b0;
        m_wack = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_owner != 2 && bus.win_req) begin
                m_owner = 2; m_wframe = bus.win_code; m_wack = 1'b1;
            end else if (m_owner != 2 && bus.alert_req && !prev_aack) begin
                m_owner = 1; m_aframe = bus.alert_code; m_aack = 1'b1; m_astart = cyc;
            end else if (m_owner == 1 && (cyc - m_astart) == AT * TD) begin
                m_owner = 0;
            end else if (m_owner == 2 && bus.win_clr) begin
                m_owner = 0;
            end
            case (m_owner)
                1:       begin m_src = SRC_ALERT; m_bcds = alert_visible(cyc - m_astart) ? m_aframe : DARK_FRAME; end
                2:       begin m_src = SRC_WIN;   m_bcds = m_wframe; end
                default: begin m_src = SRC_BASE;  m_bcds = bus.base_code; end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("bcds", bus.bcds, m_bcds);
        check("src", 16'(bus.src), 16'(m_src));
        check("alert_ack", 16'(bus.alert_ack), 16'(m_aack));
        check("win_ack", 16'(bus.win_ack), 16'(m_wack));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int n;
        bus.base_code  = 16'h1234;
        bus.alert_req  = 1'b0;
        bus.alert_code = 16'h0000;
        bus.win_req    = 1'b0;
        bus.win_code   = 16'h0000;
        bus.win_clr    = 1'b0;
        model_reset();

        // Asynchronous reset, then release.
        #2 rst_n = 1'b0;
        #1;
        check("reset_bcds", bus.bcds, 16'hAAAA);
        check("reset_src", 16'(bus.src), 16'd0);
        cycles(3);
        rst_n = 1'b1;
        cycle();
        check("base_after_release", bus.bcds, 16'h1234);

        // Plain alert lasts exactly ALERT_TICKS*TICK_DIV cycles.
        bus.alert_req = 1'b1; bus.alert_code = 16'hDEAD;
        cycle();
        check("alert_ack_pulse", 16'(bus.alert_ack), 16'd1);
        n = (bus.src == SRC_ALERT) ? 1 : 0;
        bus.alert_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.src == SRC_ALERT) n++;
        end
        check("alert_len", 16'(n), 16'(AT * TD));
        check("alert_back_to_base", bus.bcds, 16'h1234);

        // Win preempts an alert five cycles in; alert never resumes.
        bus.alert_req = 1'b1; bus.alert_code = 16'hDEAD;
        cycle();
        bus.alert_req = 1'b0;
        cycles(4);
        bus.win_req = 1'b1; bus.win_code = 16'hCDEC;
        cycle();
        check("win_preempt_ack", 16'(bus.win_ack), 16'd1);
        bus.win_req = 1'b0;
        cycles(15);
        check("win_sticky", bus.bcds, 16'hCDEC);

        // Alert held pending in S_WIN, served one cycle after the clear.
        bus.alert_req = 1'b1; bus.alert_code = 16'h0987;
        cycles(3);
        check("no_alert_in_win", 16'(bus.src), 16'(SRC_WIN));
        bus.win_clr = 1'b1;
        cycle();
        bus.win_clr = 1'b0;
        check("clr_to_base", 16'(bus.src), 16'(SRC_BASE));
        cycle();
        check("pending_alert_ack", 16'(bus.alert_ack), 16'd1);
        cycles(2);
        bus.alert_req = 1'b0;
        cycles(14);

        // Simultaneous requests, then same-cycle clear plus new win.
        bus.win_req = 1'b1; bus.win_code = 16'hCCCC;
        bus.alert_req = 1'b1; bus.alert_code = 16'hF00D;
        cycle();
        check("both_req_win_first", 16'(bus.src), 16'(SRC_WIN));
        bus.win_req = 1'b0;
        cycles(2);
        bus.win_clr = 1'b1; bus.win_req = 1'b1; bus.win_code = 16'hCE12;
        cycle();
        check("clear_wins", 16'(bus.src), 16'(SRC_BASE));
        bus.win_clr = 1'b0;
        cycle();
        check("new_win_next", bus.bcds, 16'hCE12);
        bus.win_req = 1'b0;
        bus.win_clr = 1'b1;
        cycle();
        bus.win_clr = 1'b0;
        cycle();
        bus.alert_req = 1'b0;
        cycles(14);

        // Blink pattern (or steady frame without the blink build).
        bus.alert_req = 1'b1; bus.alert_code = 16'h5555;
        cycle();
        bus.alert_req = 1'b0;
        cycles(5);
`ifdef DISP_BLINK_EN
        check("blink_dark_phase", bus.bcds, 16'hAAAA);
`else
        check("steady_frame", bus.bcds, 16'h5555);
`endif
        cycles(10);

        // Reset mid-alert with a request pending across the reset.
        bus.alert_req = 1'b1; bus.alert_code = 16'h7777;
        cycle();
        bus.alert_req = 1'b0;
        cycles(3);
        bus.alert_req = 1'b1; bus.alert_code = 16'h6666;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midalert_reset_bcds", bus.bcds, 16'hAAAA);
        check("midalert_reset_src", 16'(bus.src), 16'd0);
        cycles(2);
        rst_n = 1'b1;
        cycle();
        check("pending_after_reset", 16'(bus.alert_ack), 16'd1);
        bus.alert_req = 1'b0;
        cycles(14);

        // Random traffic obeying the req/ack protocol.
        for (int i = 0; i < 600; i++) begin
            if (m_aack) bus.alert_req = 1'b0;
            else if (!bus.alert_req && $urandom_range(0, 9) == 0) begin
                bus.alert_req = 1'b1; bus.alert_code = 16'($urandom);
            end
            if (m_wack) bus.win_req = 1'b0;
            else if (!bus.win_req && $urandom_range(0, 24) == 0) begin
                bus.win_req = 1'b1; bus.win_code = 16'($urandom);
            end
            bus.win_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.base_code = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit seven-segment display among three sources in the Connect Four top level: the base status frame (turn/score), a timed alert frame (e.g. illegal-move flash), and a sticky win banner. The block drives the 16-bit `bcds` code bus of the display driver with one frame at a time. Selection is by fixed priority with req/ack handshakes. Alert display time is measured in prescaled ticks.

## Interface
- `TICK_DIV`, default 50000: clk cycles per tick.
- `ALERT_TICKS`, default 1000: alert display duration, in ticks (≥1).
- `BLINK_TICKS`, default 250: alert blink half-period, in ticks (≥1; used only with the blink feature).
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `base_code` in 16: base frame, four 4-bit codes; always valid.
- `alert_req` in 1: alert request; held high by the requester until `alert_ack`.
- `alert_code` in 16: alert frame; sampled in the cycle `alert_ack` is high.
- `alert_ack` out 1: one-cycle accept pulse.
- `win_req` in 1: win banner request; held high until `win_ack`.
- `win_code` in 16: win frame; sampled with `win_ack`.
- `win_ack` out 1: one-cycle accept pulse.
- `win_clr` in 1: releases the win banner (new game).
- `bcds` out 16: frame to the display driver, registered.
- `src` out 2: current owner. 0 = base, 1 = alert, 2 = win.

## Operation
- Code set: 0–9 are digits, 10 is dark, 11 P, 12 W, 13 I, 14 N, 15 A. Dark frame is 16'hAAAA. Codes pass through unmodified.
- FSM states are S_BASE, S_ALERT and S_WIN. Reset state is S_BASE.
- S_BASE:
  - `win_req` → latch `win_code`, pulse `win_ack`, go to S_WIN.
  - Otherwise `alert_req` → latch `alert_code`, pulse `alert_ack`, load the tick counter with ALERT_TICKS, restart the prescaler, go to S_ALERT.
  - If both requests are high, win is served first; the alert stays pending.
- S_ALERT:
  - `win_req` preempts: the win is accepted as above and the alert is discarded.
  - A new `alert_req` restarts the alert: latch, ack, reload counter, restart prescaler.
  - The counter decrements on each tick. On the tick where it reaches 0, go to S_BASE.
- S_WIN:
  - Holds until `win_clr`, then goes to S_BASE.
  - `alert_req` and `win_req` are not acked here and stay pending.
  - If `win_clr` and `win_req` arrive in the same cycle, the clear wins. The pending `win_req` is accepted next cycle from S_BASE.
- Output mux: S_BASE shows `base_code`, S_ALERT shows the latched alert frame, S_WIN shows the latched win frame.
- Ack pulses never last longer than one cycle, even if a requester holds req high. The requester must drop req the cycle after ack; a req still high two cycles after ack counts as a new request.
- Counter widths: prescaler is $clog2(TICK_DIV) bits; alert counter is $clog2(ALERT_TICKS+1) bits. Neither wraps; both reload on alert acceptance.

## Timing
- Reset values: `bcds` = 16'hAAAA, `src` = 0, `alert_ack` = 0, `win_ack` = 0, all counters 0, blink phase visible.
- The ack is registered and asserts the cycle after req is sampled high in an accepting state.
- `bcds` and `src` update in the same cycle as the ack.
- In S_BASE, `bcds` follows `base_code` with 1-cycle latency.
- Alert duration is exactly ALERT_TICKS×TICK_DIV cycles from the ack to `src` returning to 0.
- Reset asserted mid-alert or mid-win: immediate return to reset values. Pending requests are re-evaluated after release.

## Configuration
- `DISP_BLINK_EN` defined: in S_ALERT the blink phase toggles every BLINK_TICKS ticks. The phase starts visible at each alert acceptance. In the dark phase `bcds` = 16'hAAAA; `src` stays 1.
- `DISP_BLINK_EN` undefined: the alert frame is steady. The blink counter and phase logic are not compiled.

## Structure
- Package `disp_pkg` holds:
  - code constants CODE_DARK=4'hA, CODE_P=4'hB, CODE_W=4'hC, CODE_I=4'hD, CODE_N=4'hE, CODE_A=4'hF;
  - DARK_FRAME=16'hAAAA;
  - the FSM state enum;
  - the `src` encodings.
- Sub-module `disp_tick_gen`: prescaler with synchronous restart input and a one-cycle `tick` output every TICK_DIV cycles.

## Test plan
Bench parameters: TICK_DIV=4, ALERT_TICKS=3, BLINK_TICKS=1.
- Reset, then release with `base_code`=16'h1234 → `bcds`=16'hAAAA during reset; 16'h1234 and `src`=0 one cycle after release.
- `alert_req` with `alert_code`=16'hDEAD → `alert_ack` pulses once; `bcds`=16'hDEAD, `src`=1 for exactly 12 cycles, then back to 16'h1234.
- `win_req` (`win_code`=16'hCDEC) raised 5 cycles into an alert → `win_ack`, `bcds`=16'hCDEC, `src`=2; the alert never resumes.
- In S_WIN with `alert_req` held high → no `alert_ack`. Pulse `win_clr` → S_BASE, then `alert_ack` one cycle later.
- `win_req` and `alert_req` in the same cycle from S_BASE → `win_ack` only. Same-cycle `win_clr` plus a new `win_req` → clear first, new win accepted the next cycle.
- With `DISP_BLINK_EN`, alert 16'h5555 → `bcds` alternates 16'h5555 / 16'hAAAA every 4 cycles, starting visible. Without the macro it stays at 16'h5555.
